// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the memory
// stage: fixed data-over-inst priority, a single outstanding transaction.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_data_ok,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_data_ok,
  output logic                data_stall,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = inst, 1 = data
  logic                cancel_q, cancel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [BE_W-1:0]     wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                inst_ok_q, inst_ok_d;
  logic                data_ok_q, data_ok_d;
  logic [DATA_W-1:0]   rd_word;

  // Next-state, latch and completion logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancel_d     = cancel_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    rd_word      = wr_q ? '0 : mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          owner_d = 1'b1;
          addr_d  = data_addr;
          wr_d    = data_wr;
          wen_d   = data_wr ? data_wen : '0;
          wdata_d = data_wdata;
          state_d = S_REQ;
        end else if (inst_req) begin
          owner_d = 1'b0;
          addr_d  = inst_addr;
          wr_d    = 1'b0;
          wen_d   = '0;
          wdata_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A flushed fetch that was already accepted must still drain its data beat
        if (mem_addr_ok) begin
          state_d = S_WAIT;
          if (flush && !owner_q) cancel_d = 1'b1;
        end else if (flush && !owner_q) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush && !owner_q) cancel_d = 1'b1;
        if (mem_data_ok) begin
          state_d = S_DONE;
          if (owner_q)        data_rdata_d = rd_word;
          else if (!cancel_d) inst_rdata_d = rd_word;
        end
      end
      S_DONE: begin
        cancel_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
    inst_ok_d = (state_d == S_DONE) && !owner_d && !cancel_d;
    data_ok_d = (state_d == S_DONE) && owner_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      cancel_q     <= 1'b0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wen_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cancel_q     <= cancel_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      mem_req_q    <= mem_req_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_wr       = wr_q;
  assign mem_wen      = wen_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign inst_rdata   = inst_rdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_rdata   = data_rdata_q;
  assign data_data_ok = data_ok_q;

  // Hazard-unit stall requests follow the live request lines
  assign inst_stall = inst_req & ~inst_ok_q;
  assign data_stall = data_req & ~data_ok_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scripted scenarios plus randomized traffic checked
// against a transaction-level latency/ordering model and a reference memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0, inst_data_ok, inst_stall;
  logic [31:0] inst_addr = '0, inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0, data_data_ok, data_stall;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic        flush = 1'b0;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_data_ok(inst_data_ok), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .data_stall(data_stall),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit auto_mem = 1'b0;
  int aw_cfg = 0;
  int dw_cfg = 0;
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dm_read(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    rmem[a] = merge(ref_read(a), d, be);
  endtask

  // Downstream memory: accepts after aw_cfg extra cycles, answers dw_cfg extra cycles later
  initial begin : responder
    bit busy;
    int rcnt, dcnt;
    logic [31:0] la, lwd;
    logic lwr;
    logic [3:0] lbe;
    busy = 0; rcnt = 0; dcnt = 0; la = '0; lwd = '0; lwr = 1'b0; lbe = '0;
    forever begin
      @(posedge clk); #1;
      if (auto_mem) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (!rst) begin
          busy = 0; rcnt = 0;
        end else if (busy) begin
          if (dcnt >= dw_cfg) begin
            mem_data_ok = 1'b1;
            if (lwr) begin
              dmem[la] = merge(dm_read(la), lwd, lbe);
              mem_rdata = $urandom;
            end else begin
              mem_rdata = dm_read(la);
            end
            busy = 0;
          end else dcnt++;
        end else if (mem_req) begin
          if (rcnt >= aw_cfg) begin
            mem_addr_ok = 1'b1;
            la = mem_addr; lwr = mem_wr; lbe = mem_wen; lwd = mem_wdata;
            busy = 1; dcnt = 0; rcnt = 0;
          end else rcnt++;
        end else rcnt = 0;
      end else begin
        busy = 0; rcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wen = '0; flush = 1'b0;
  endtask

  task automatic wait_ok(input bit is_data, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (is_data ? data_data_ok : inst_data_ok) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    int t0;
    auto_mem = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inst_req = 1'($urandom); inst_addr = $urandom; data_req = 1'($urandom);
      data_wr = 1'($urandom); data_wen = 4'($urandom); data_addr = $urandom;
      data_wdata = $urandom; flush = 1'($urandom); mem_addr_ok = 1'($urandom);
      mem_data_ok = 1'($urandom); mem_rdata = $urandom;
      tick();
      checks++;
      if ({mem_req, mem_wr, mem_wen, mem_addr, mem_wdata, inst_rdata, inst_data_ok,
           data_rdata, data_data_ok} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0", {mem_req, mem_wr, mem_wen, mem_addr,
                 mem_wdata, inst_rdata, inst_data_ok, data_rdata, data_data_ok});
      end
      checks++;
      if (inst_stall !== inst_req || data_stall !== data_req) begin
        errors++;
        $display("FAIL reset_stall: got %b%b want %b%b", inst_stall, data_stall, inst_req, data_req);
      end
    end
    idle_inputs();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    aw_cfg = 0; dw_cfg = 0; auto_mem = 1'b1;
    tick();
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    t0 = cyc;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000 || mem_wr !== 1'b0 || mem_wen !== 4'h0) begin
      errors++;
      $display("FAIL first_fetch_req: got req=%b addr=%h wr=%b wen=%h want 1 bfc00000 0 0",
               mem_req, mem_addr, mem_wr, mem_wen);
    end
    wait_ok(1'b0, 20, seen);
    checks++;
    if (!seen || cyc - t0 != 3) begin
      errors++;
      $display("FAIL first_fetch_latency: got seen=%b cyc=%0d want 3", seen, cyc - t0);
    end
    checks++;
    if (inst_rdata !== ref_read(32'hBFC00000)) begin
      errors++;
      $display("FAIL first_fetch_rdata: got %h want %h", inst_rdata, ref_read(32'hBFC00000));
    end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    int t0, dlat, ilat;
    bit stall_ok, dstall_at_ok;
    logic [31:0] drd, ird;
    dlat = -1; ilat = -1; stall_ok = 1'b1; dstall_at_ok = 1'b1; drd = '0; ird = '0;
    data_req = 1'b1; data_wr = 1'b0; data_wen = 4'hF; data_addr = 32'h80000010;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    t0 = cyc;
    tick();
    checks++;
    if (mem_addr !== 32'h80000010 || mem_wr !== 1'b0 || mem_wen !== 4'h0 || data_stall !== 1'b1) begin
      errors++;
      $display("FAIL prio_grant: got addr=%h wr=%b wen=%h dstall=%b want 80000010 0 0 1",
               mem_addr, mem_wr, mem_wen, data_stall);
    end
    for (int i = 0; i < 30; i++) begin
      if (!inst_data_ok && inst_stall !== 1'b1) stall_ok = 1'b0;
      if (data_data_ok) begin
        dlat = cyc - t0; drd = data_rdata; dstall_at_ok = data_stall; data_req = 1'b0;
      end
      if (inst_data_ok) begin
        ilat = cyc - t0; ird = inst_rdata; inst_req = 1'b0;
        break;
      end
      tick();
    end
    checks++;
    if (dlat != 3 || dstall_at_ok !== 1'b0) begin
      errors++;
      $display("FAIL prio_data_first: got lat=%0d stall=%b want 3 0", dlat, dstall_at_ok);
    end
    checks++;
    if (drd !== ref_read(32'h80000010)) begin
      errors++;
      $display("FAIL prio_data_rdata: got %h want %h", drd, ref_read(32'h80000010));
    end
    checks++;
    if (ilat != 7 || ird !== ref_read(32'hBFC00004)) begin
      errors++;
      $display("FAIL prio_inst_after: got lat=%0d rdata=%h want 7 %h", ilat, ird, ref_read(32'hBFC00004));
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL prio_inst_stall: got a low inst_stall want 1 throughout");
    end
    tick();
  endtask

  task automatic test_store();
    bit seen;
    int t0;
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011;
    data_wdata = 32'h1234ABCD; data_addr = 32'h80000020;
    ref_write(32'h80000020, 32'h1234ABCD, 4'b0011);
    t0 = cyc;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wen !== 4'b0011 ||
        mem_wdata !== 32'h1234ABCD || mem_addr !== 32'h80000020) begin
      errors++;
      $display("FAIL store_req: got req=%b wr=%b wen=%b wd=%h a=%h want 1 1 0011 1234abcd 80000020",
               mem_req, mem_wr, mem_wen, mem_wdata, mem_addr);
    end
    wait_ok(1'b1, 20, seen);
    checks++;
    if (!seen || cyc - t0 != 3 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_done: got seen=%b lat=%0d rdata=%h want 1 3 0", seen, cyc - t0, data_rdata);
    end
    data_req = 1'b0; data_wr = 1'b0;
    tick();
    data_req = 1'b1; data_wen = 4'h0;
    wait_ok(1'b1, 20, seen);
    checks++;
    if (!seen || data_rdata !== ref_read(32'h80000020)) begin
      errors++;
      $display("FAIL store_readback: got %h want %h", data_rdata, ref_read(32'h80000020));
    end
    data_req = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int t0, req_cyc;
    bit seen, stable;
    aw_cfg = 3; dw_cfg = 1;
    req_cyc = 0; stable = 1'b1; seen = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000044;
    t0 = cyc;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_req) begin
        req_cyc++;
        if (mem_addr !== 32'h80000044) stable = 1'b0;
      end
      if (data_data_ok) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (req_cyc != 4 || !stable) begin
      errors++;
      $display("FAIL bp_req_hold: got cycles=%0d stable=%b want 4 1", req_cyc, stable);
    end
    checks++;
    if (!seen || cyc - t0 != 7 || data_rdata !== ref_read(32'h80000044)) begin
      errors++;
      $display("FAIL bp_latency: got seen=%b lat=%0d rdata=%h want 1 7 %h",
               seen, cyc - t0, data_rdata, ref_read(32'h80000044));
    end
    data_req = 1'b0; aw_cfg = 0; dw_cfg = 0;
    tick();
  endtask

  task automatic test_flush_wait();
    int t0, lat, nok;
    logic [31:0] rd;
    lat = -1; nok = 0; rd = '0;
    dw_cfg = 3;
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    t0 = cyc;
    tick();
    tick();
    flush = 1'b1; inst_addr = 32'hBFC00380;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_data_ok) begin
        nok++;
        if (lat < 0) begin lat = cyc - t0; rd = inst_rdata; end
        inst_req = 1'b0;
      end
      if (lat >= 0 && cyc - t0 > 16) break;
      tick();
    end
    checks++;
    if (lat != 13 || nok != 1) begin
      errors++;
      $display("FAIL flush_wait_cancel: got first_ok=%0d count=%0d want 13 1", lat, nok);
    end
    checks++;
    if (rd !== ref_read(32'hBFC00380)) begin
      errors++;
      $display("FAIL flush_wait_refetch: got %h want %h", rd, ref_read(32'hBFC00380));
    end
    inst_req = 1'b0; dw_cfg = 0;
    tick();
  endtask

  task automatic test_flush_data();
    int t0;
    bit seen;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000060;
    t0 = cyc;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = data_data_ok;
    checks++;
    if (!seen || cyc - t0 != 3 || data_rdata !== ref_read(32'h80000060)) begin
      errors++;
      $display("FAIL flush_data_immune: got seen=%b lat=%0d rdata=%h want 1 3 %h",
               seen, cyc - t0, data_rdata, ref_read(32'h80000060));
    end
    data_req = 1'b0;
    tick();
  endtask

  task automatic test_flush_req();
    int bad;
    aw_cfg = 5;
    inst_req = 1'b1; inst_addr = 32'hBFC00200;
    tick();
    flush = 1'b1; inst_req = 1'b0;
    tick();
    flush = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_abort: got mem_req=%b want 0", mem_req);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst_data_ok || mem_req) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_req_quiet: got %0d active cycles want 0", bad);
    end
    aw_cfg = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC00204;
    tick();
    flush = 1'b1; inst_req = 1'b0;
    tick();
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_data_ok || mem_req) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_req_accepted: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    dw_cfg = 5;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000050;
    tick(); tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_wr, mem_wen, mem_addr, mem_wdata, inst_rdata, inst_data_ok,
           data_rdata, data_data_ok} !== '0) begin
        errors++;
        $display("FAIL mid_reset_outputs: got %h want 0", {mem_req, mem_wr, mem_wen, mem_addr,
                 mem_wdata, inst_rdata, inst_data_ok, data_rdata, data_data_ok});
      end
    end
    data_req = 1'b0;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (data_data_ok || inst_data_ok || mem_req) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_stale: got %0d active cycles want 0", bad);
    end
    dw_cfg = 0;
  endtask

  task automatic test_random();
    int kind, t0, lat_one, exp_ilat, dlat, ilat;
    logic [31:0] ia, da, dwd, exp_d, exp_i, drd, ird;
    logic dwr;
    logic [3:0] dbe;
    bit want_i, want_d;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      want_i = (kind != 1);
      want_d = (kind != 0);
      aw_cfg = $urandom_range(0, 3);
      dw_cfg = $urandom_range(0, 3);
      ia = 32'hBFC00000 | (32'($urandom_range(0, 15)) << 2);
      da = 32'h80000000 | (32'($urandom_range(0, 15)) << 2);
      dwr = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
      exp_i = ref_read(ia);
      exp_d = dwr ? 32'h0 : ref_read(da);
      if (want_d && dwr) ref_write(da, dwd, dbe);
      lat_one = 3 + aw_cfg + dw_cfg;
      exp_ilat = want_d ? 2 * lat_one + 1 : lat_one;
      dlat = -1; ilat = -1; drd = '0; ird = '0;
      inst_req = want_i; inst_addr = ia;
      data_req = want_d; data_wr = dwr; data_wen = dbe; data_addr = da; data_wdata = dwd;
      t0 = cyc;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (data_data_ok) begin dlat = cyc - t0; drd = data_rdata; data_req = 1'b0; end
        if (inst_data_ok) begin ilat = cyc - t0; ird = inst_rdata; inst_req = 1'b0; end
        if (!inst_req && !data_req) break;
      end
      if (want_d) begin
        checks++;
        if (dlat != lat_one || drd !== exp_d) begin
          errors++;
          $display("FAIL rand_data[%0d]: got lat=%0d rdata=%h want %0d %h", it, dlat, drd, lat_one, exp_d);
        end
      end
      if (want_i) begin
        checks++;
        if (ilat != exp_ilat || ird !== exp_i) begin
          errors++;
          $display("FAIL rand_inst[%0d]: got lat=%0d rdata=%h want %0d %h", it, ilat, ird, exp_ilat, exp_i);
        end
      end
      idle_inputs();
      tick();
    end
    aw_cfg = 0; dw_cfg = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_priority();
    test_store();
    test_backpressure();
    test_flush_wait();
    test_flush_data();
    test_flush_req();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single SRAM-like memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores, byte-enabled). Fixed priority, one outstanding transaction. Per-port stall requests feed the hazard unit. An exception flush cancels an in-flight instruction fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports (byte enables are DATA_W/8 wide)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
inst_req  in  1  fetch request; held with stable inst_addr until inst_data_ok
inst_addr  in  ADDR_W  fetch address (pcF)
inst_rdata  out  DATA_W  fetched word; valid while inst_data_ok=1
inst_data_ok  out  1  one-cycle completion pulse for fetch
inst_stall  out  1  fetch stall request to hazard unit
data_req  in  1  data request; held stable until data_data_ok
data_wr  in  1  1=store, 0=load
data_wen  in  DATA_W/8  byte write enables (writeEnM)
data_addr  in  ADDR_W  data address (aluoutM)
data_wdata  in  DATA_W  store data (writedata_decodedM)
data_rdata  out  DATA_W  load data; valid while data_data_ok=1
data_data_ok  out  1  one-cycle completion pulse for data
data_stall  out  1  memory-stage stall request to hazard unit
flush  in  1  exception flush (flush_except)
mem_req  out  1  downstream request
mem_wr  out  1  downstream write flag
mem_wen  out  DATA_W/8  downstream byte enables (0 for reads)
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_addr_ok  in  1  downstream accepted request this cycle
mem_data_ok  in  1  downstream read data valid / write done this cycle
mem_rdata  in  DATA_W  downstream read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Internal regs: owner (0=inst, 1=data), latched addr/wr/wen/wdata, rdata buffer, cancel flag.
- Reset (rst=0, async): state=IDLE, owner=0, cancel=0, all outputs and latched regs 0. Reset mid-transaction abandons it; no data_ok is issued after reset release.
- IDLE: if data_req, grant data (owner=1); else if inst_req, grant inst (owner=0). Latch the requester's fields and go to REQ. inst_addr is latched with mem_wr=0, mem_wen=0 and mem_wdata=0. flush has no effect in IDLE.
- REQ: mem_req=1 and mem_* driven from latched regs. On mem_addr_ok=1 go to WAIT.
- Flush in REQ for an inst transaction: if mem_addr_ok=0, abort to IDLE (mem_req drops the next cycle, no inst_data_ok). If mem_addr_ok=1 in the same cycle, go to WAIT with cancel=1.
- WAIT: mem_req=0. flush=1 with owner=0 sets cancel. On mem_data_ok=1, capture mem_rdata (reads only; writes capture 0) and go to DONE.
- DONE (exactly 1 cycle): owner's *_data_ok=1 with *_rdata=buffer, except that inst_data_ok is suppressed if cancel=1. Clear cancel and go to IDLE. Requests are not sampled in DONE.
- *_rdata holds its last value when not valid. *_data_ok is 0 outside DONE.
- inst_stall = inst_req & ~inst_data_ok. data_stall = data_req & ~data_data_ok. Both are combinational.
- Minimum latency: request seen in IDLE at cycle 0, REQ cycle 1 (addr_ok=1), WAIT cycle 2 (data_ok=1), data_ok at cycle 3. Each downstream wait cycle adds one.
- Priority is fixed data > inst; data belongs to the older instruction. Starvation is impossible because data_stall freezes the front end.
- flush never affects data transactions. Data requests from excepting instructions are gated upstream.
- Simultaneous mem_addr_ok and mem_data_ok in REQ is illegal downstream behaviour. The arbiter only honours mem_addr_ok in that cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release with inst_req=1, inst_addr=0xBFC00000, zero-wait memory -> mem_addr=0xBFC00000 at cycle 1, inst_data_ok at cycle 3 with inst_rdata=memory word.
- Simultaneous requests: data_req (load, addr 0x80000010) and inst_req (0xBFC00004) in the same IDLE cycle -> data served first, data_stall drops with data_data_ok, then inst granted from next IDLE; inst_stall stays 1 throughout.
- Store: data_wr=1, data_wen=4'b0011, data_wdata=0x1234ABCD, addr 0x80000020 -> mem_wr=1, mem_wen=0011, mem_wdata=0x1234ABCD during REQ; data_data_ok pulse after mem_data_ok.
- Backpressure: mem_addr_ok low 3 cycles, mem_data_ok 2 cycles after acceptance -> mem_req high 4 cycles, addr stable, data_ok at cycle 7.
- Flush in WAIT on fetch -> inst_data_ok never asserts, state returns IDLE, a new inst_req to 0xBFC00380 completes normally.
- Flush in REQ with mem_addr_ok=0 -> immediate return to IDLE. Mid-WAIT rst pulse -> outputs 0, no stale data_ok after release.
